// File: rtl/fwd_hazard_unit.sv
// Forwarding and hazard unit: shadows dest/write-back info for stages S1(EXE)..S_NSTG(WB),
// drives per-operand forward selects for EXE, raises stall on unresolvable RAW hazards.
module fwd_hazard_unit #(
  parameter int NSTG     = 3,
  parameter int NSRC     = 2,
  parameter int RW       = 4,
  parameter int LOAD_RDY = 3,
  parameter int RF_BYP   = 1,
  parameter int CNT_W    = 16,
  localparam int SELW    = $clog2(NSTG)
) (
  input  logic                 i_clk,
  input  logic                 i_rst,
  input  logic                 i_fwd_en,
  input  logic                 i_flush,
  input  logic                 i_id_valid,
  input  logic [NSRC*RW-1:0]   i_id_src,
  input  logic [NSRC-1:0]      i_id_src_used,
  input  logic [RW-1:0]        i_id_dest,
  input  logic                 i_id_wb_en,
  input  logic                 i_id_is_load,
  output logic                 o_stall,
  output logic [NSRC*SELW-1:0] o_ex_sel,
  output logic [CNT_W-1:0]     o_stall_cnt
);

  logic              r_vld [1:NSTG];
  logic [RW-1:0]     r_dst [1:NSTG];
  logic              r_wb  [1:NSTG];
  logic              r_ld  [1:NSTG];
  logic [NSRC*RW-1:0] r_s1_src;
  logic [NSRC-1:0]   r_s1_used;
  logic [CNT_W-1:0]  r_cnt;

  logic                 w_stall;
  logic [NSRC*SELW-1:0] w_sel;

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      for (int j = 1; j <= NSTG; j++) begin
        r_vld[j] <= 1'b0;
        r_dst[j] <= '0;
        r_wb[j]  <= 1'b0;
        r_ld[j]  <= 1'b0;
      end
      r_s1_src  <= '0;
      r_s1_used <= '0;
      r_cnt     <= '0;
    end else begin
      for (int j = 2; j <= NSTG; j++) begin
        r_vld[j] <= r_vld[j-1];
        r_dst[j] <= r_dst[j-1];
        r_wb[j]  <= r_wb[j-1];
        r_ld[j]  <= r_ld[j-1];
      end
      // Payload is loaded unconditionally; only the valid bit encodes a bubble.
      r_vld[1]  <= i_id_valid & ~w_stall & ~i_flush;
      r_dst[1]  <= i_id_dest;
      r_wb[1]   <= i_id_wb_en;
      r_ld[1]   <= i_id_is_load;
      r_s1_src  <= i_id_src;
      r_s1_used <= i_id_src_used;
      if (w_stall && (r_cnt != {CNT_W{1'b1}}))
        r_cnt <= r_cnt + 1'b1;
    end
  end

  // Descending scan: the last hit written is the youngest producer.
  always_comb begin
    w_sel = '0;
    if (i_fwd_en && r_vld[1]) begin
      for (int i = 0; i < NSRC; i++) begin
        if (r_s1_used[i]) begin
          for (int j = NSTG; j >= 2; j--) begin
            if (r_vld[j] && r_wb[j] && (r_dst[j] == r_s1_src[i*RW +: RW]))
              w_sel[i*SELW +: SELW] = SELW'(j - 1);
          end
        end
      end
    end
  end

  always_comb begin
    logic w_op_hz;
    logic w_hz_any;
    w_hz_any = 1'b0;
    for (int i = 0; i < NSRC; i++) begin
      w_op_hz = 1'b0;
      if (i_id_src_used[i]) begin
        for (int j = NSTG; j >= 1; j--) begin
          if (r_vld[j] && r_wb[j] && (r_dst[j] == i_id_src[i*RW +: RW])) begin
            if (i_fwd_en)
              w_op_hz = r_ld[j] && ((j + 1) < LOAD_RDY);
            else
              w_op_hz = (j < NSTG) || (RF_BYP == 0);
          end
        end
      end
      w_hz_any = w_hz_any | w_op_hz;
    end
    w_stall = i_id_valid & ~i_flush & w_hz_any;
  end

  assign o_stall     = w_stall;
  assign o_ex_sel    = w_sel;
  assign o_stall_cnt = r_cnt;

endmodule

// File: tb/tb_fwd_hazard_unit.sv
// Bench for fwd_hazard_unit: directed scenarios with literal expectations plus randomized
// traffic, all checked every cycle against an instruction-history model.
module tb_fwd_hazard_unit;
  localparam int NSTG = 3, NSRC = 2, RW = 4, LOAD_RDY = 3, RF_BYP = 1, CNT_W = 5;
  localparam int SELW = $clog2(NSTG);
  localparam int CMAX = (1 << CNT_W) - 1;

  logic i_clk = 0, i_rst = 1, i_fwd_en = 1, i_flush = 0, i_id_valid = 0;
  logic [NSRC*RW-1:0] i_id_src = '0;
  logic [NSRC-1:0] i_id_src_used = '0;
  logic [RW-1:0] i_id_dest = '0;
  logic i_id_wb_en = 0, i_id_is_load = 0;
  logic o_stall;
  logic [NSRC*SELW-1:0] o_ex_sel;
  logic [CNT_W-1:0] o_stall_cnt;

  fwd_hazard_unit #(.NSTG(NSTG), .NSRC(NSRC), .RW(RW), .LOAD_RDY(LOAD_RDY),
                    .RF_BYP(RF_BYP), .CNT_W(CNT_W)) dut (
    .i_clk(i_clk), .i_rst(i_rst), .i_fwd_en(i_fwd_en), .i_flush(i_flush),
    .i_id_valid(i_id_valid), .i_id_src(i_id_src), .i_id_src_used(i_id_src_used),
    .i_id_dest(i_id_dest), .i_id_wb_en(i_id_wb_en), .i_id_is_load(i_id_is_load),
    .o_stall(o_stall), .o_ex_sel(o_ex_sel), .o_stall_cnt(o_stall_cnt));

  always #5 i_clk = ~i_clk;

  typedef struct {
    bit vld; bit [RW-1:0] dst; bit wb; bit ld;
    bit [NSRC*RW-1:0] src; bit [NSRC-1:0] used;
  } ent_t;

  // hist[0] is the instruction in EXE (S1), hist[k] the one in S(k+1).
  ent_t hist[$];
  int m_cnt = 0;
  int n_cmp = 0, n_bad = 0;
  bit chk_en = 0;

  task automatic chk(string nm, logic [31:0] act, logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
    end
  endtask

  function automatic bit m_stall();
    bit hz = 0;
    if (!i_id_valid || i_flush) return 0;
    for (int i = 0; i < NSRC; i++) begin
      if (i_id_src_used[i]) begin
        for (int k = 0; k < NSTG; k++) begin
          if (hist[k].vld && hist[k].wb && hist[k].dst == i_id_src[i*RW +: RW]) begin
            if (i_fwd_en) hz |= hist[k].ld && ((k + 2) < LOAD_RDY);
            else          hz |= ((k + 1) < NSTG) || (RF_BYP == 0);
            break;
          end
        end
      end
    end
    return hz;
  endfunction

  function automatic logic [NSRC*SELW-1:0] m_sel();
    logic [NSRC*SELW-1:0] s = '0;
    if (!i_fwd_en || !hist[0].vld) return s;
    for (int i = 0; i < NSRC; i++) begin
      if (hist[0].used[i]) begin
        for (int k = 1; k < NSTG; k++) begin
          if (hist[k].vld && hist[k].wb && hist[k].dst == hist[0].src[i*RW +: RW]) begin
            s[i*SELW +: SELW] = SELW'(k);
            break;
          end
        end
      end
    end
    return s;
  endfunction

  function automatic void m_clear();
    ent_t z = '{default: 0};
    hist.delete();
    for (int k = 0; k < NSTG; k++) hist.push_back(z);
  endfunction

  always @(posedge i_clk) begin
    ent_t e;
    bit st;
    if (i_rst) begin
      m_clear();
      m_cnt = 0;
    end else begin
      st = m_stall();
      e.vld = i_id_valid && !st && !i_flush;
      e.dst = i_id_dest; e.wb = i_id_wb_en; e.ld = i_id_is_load;
      e.src = i_id_src; e.used = i_id_src_used;
      hist.push_front(e);
      void'(hist.pop_back());
      if (st && m_cnt != CMAX) m_cnt++;
    end
  end

  always @(negedge i_clk) begin
    if (chk_en) begin
      chk("stall", 32'(o_stall), 32'(m_stall()));
      chk("ex_sel", 32'(o_ex_sel), 32'(m_sel()));
      chk("stall_cnt", 32'(o_stall_cnt), 32'(m_cnt));
    end
  end

  task automatic id_set(bit v, bit [RW-1:0] s0, bit [RW-1:0] s1, bit [1:0] u,
                        bit [RW-1:0] d, bit wb, bit ld, bit fl);
    i_id_valid = v; i_id_src = {s1, s0}; i_id_src_used = u;
    i_id_dest = d; i_id_wb_en = wb; i_id_is_load = ld; i_flush = fl;
  endtask
  task automatic nop();   id_set(0, 0, 0, 2'b00, 0, 0, 0, 0); endtask
  task automatic tick();  @(posedge i_clk); #1; endtask
  task automatic at_neg(); @(negedge i_clk); endtask
  task automatic do_reset();
    i_rst = 1; nop(); tick(); i_rst = 0;
  endtask

  initial begin
    m_clear();
    do_reset();
    chk_en = 1;

    // reset state
    at_neg();
    chk("rst_stall", 32'(o_stall), 0);
    chk("rst_sel", 32'(o_ex_sel), 0);
    chk("rst_cnt", 32'(o_stall_cnt), 0);

    // ADD r1; SUB r2,r1,r3 -> forward from MEM
    id_set(1, 2, 3, 2'b11, 1, 1, 0, 0); tick();
    id_set(1, 1, 3, 2'b11, 2, 1, 0, 0); at_neg();
    chk("alu_nostall", 32'(o_stall), 0);
    tick(); nop(); at_neg();
    chk("fwd_mem", 32'(o_ex_sel), 32'h1);
    chk("model_mem", 32'(m_sel()), 32'h1);

    // ADD r1; NOP; SUB r1 -> forward from WB
    do_reset();
    id_set(1, 2, 3, 2'b11, 1, 1, 0, 0); tick();
    nop(); tick();
    id_set(1, 1, 3, 2'b11, 2, 1, 0, 0); tick();
    nop(); at_neg();
    chk("fwd_wb", 32'(o_ex_sel), 32'h2);
    // r1 in MEM and WB -> youngest (MEM)
    id_set(1, 2, 3, 2'b11, 1, 1, 0, 0); tick();
    id_set(1, 2, 3, 2'b11, 1, 1, 0, 0); tick();
    id_set(1, 1, 3, 2'b11, 2, 1, 0, 0); tick();
    nop(); at_neg();
    chk("fwd_youngest", 32'(o_ex_sel), 32'h1);

    // LDR r4; ADD r5,r4,r4 -> one stall, then WB forward on both operands
    do_reset();
    id_set(1, 0, 0, 2'b00, 4, 1, 1, 0); tick();
    id_set(1, 4, 4, 2'b11, 5, 1, 0, 0); at_neg();
    chk("lu_stall1", 32'(o_stall), 1);
    tick(); at_neg();
    chk("lu_stall2", 32'(o_stall), 0);
    tick(); nop(); at_neg();
    chk("lu_sel", 32'(o_ex_sel), 32'hA);
    chk("lu_cnt", 32'(o_stall_cnt), 1);

    // forwarding off: ADD r1; SUB r1 -> two stalls with regfile bypass
    do_reset();
    i_fwd_en = 0;
    id_set(1, 2, 3, 2'b11, 1, 1, 0, 0); tick();
    id_set(1, 1, 3, 2'b11, 2, 1, 0, 0); at_neg();
    chk("nf_stall1", 32'(o_stall), 1);
    tick(); at_neg();
    chk("nf_stall2", 32'(o_stall), 1);
    tick(); at_neg();
    chk("nf_stall3", 32'(o_stall), 0);
    tick(); nop(); at_neg();
    chk("nf_sel", 32'(o_ex_sel), 0);
    chk("nf_cnt", 32'(o_stall_cnt), 2);
    i_fwd_en = 1;

    // load-use coinciding with flush
    do_reset();
    id_set(1, 0, 0, 2'b00, 4, 1, 1, 0); tick();
    id_set(1, 4, 4, 2'b11, 5, 1, 0, 1); at_neg();
    chk("fl_stall", 32'(o_stall), 0);
    tick(); nop(); at_neg();
    chk("fl_sel", 32'(o_ex_sel), 0);
    chk("fl_cnt", 32'(o_stall_cnt), 0);

    // saturate the counter, then reset in the middle of a stall
    do_reset();
    for (int n = 0; n < 40; n++) begin
      id_set(1, 0, 0, 2'b00, 4, 1, 1, 0); tick();
      id_set(1, 4, 4, 2'b11, 5, 1, 0, 0); tick(); tick();
    end
    at_neg();
    chk("sat_cnt", 32'(o_stall_cnt), 32'(CMAX));
    id_set(1, 0, 0, 2'b00, 4, 1, 1, 0); tick();
    id_set(1, 4, 4, 2'b11, 5, 1, 0, 0); at_neg();
    chk("sat_stall", 32'(o_stall), 1);
    tick(); at_neg();
    chk("sat_hold", 32'(o_stall_cnt), 32'(CMAX));
    id_set(1, 0, 0, 2'b00, 4, 1, 1, 0); tick();
    id_set(1, 4, 4, 2'b11, 5, 1, 0, 0); at_neg();
    chk("mid_stall", 32'(o_stall), 1);
    i_rst = 1; tick(); i_rst = 0; at_neg();
    chk("rst_mid_stall", 32'(o_stall), 0);
    chk("rst_mid_sel", 32'(o_ex_sel), 0);
    chk("rst_mid_cnt", 32'(o_stall_cnt), 0);

    // randomized traffic on a small register set to provoke hazards
    for (int n = 0; n < 3000; n++) begin
      i_rst = ($urandom_range(0, 199) == 0);
      if ($urandom_range(0, 19) == 0) i_fwd_en = ~i_fwd_en;
      id_set($urandom_range(0, 9) < 8,
             RW'($urandom_range(0, 3)), RW'($urandom_range(0, 3)),
             2'($urandom_range(0, 3)), RW'($urandom_range(0, 3)),
             $urandom_range(0, 9) < 8, $urandom_range(0, 9) < 3,
             $urandom_range(0, 9) == 0);
      tick();
    end
    i_rst = 0;
    at_neg();
    chk_en = 0;

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
